// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scans a 4x4 matrix keypad one column at a time, debounces
// press and release, and hands out one key code per press via valid/ready.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] btn_key_col,
  input  logic [3:0] btn_key_row,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow,
  input  logic       ovf_clr
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [8:0]  DEB_TGT  = 9'(DEBOUNCE_TICKS);

  state_t      state;
  logic [15:0] div_cnt;
  logic        tick;
  logic [3:0]  sync1;
  logic [3:0]  srow;
  logic [1:0]  col;
  logic [1:0]  cand_row;
  logic [1:0]  cand_col;
  logic [7:0]  deb_cnt;
  logic [7:0]  rel_cnt;
  logic [1:0]  low_row;
  logic        cand_pressed;
  logic        deb_done;
  logic        rel_done;
  logic        accept;
  logic [1:0]  acc_row;
  logic [1:0]  acc_col;
  logic        ovf_set;

  assign tick         = (div_cnt == DIV_LAST);
  assign cand_pressed = ~srow[cand_row];
  assign deb_done     = (({1'b0, deb_cnt} + 9'd1) == DEB_TGT);
  assign rel_done     = (({1'b0, rel_cnt} + 9'd1) == DEB_TGT);
  assign btn_key_col  = ~(4'b0001 << col);
  assign ovf_set      = accept && key_valid && !key_ready;

  // Lowest pressed row wins when several rows in one column read low.
  always_comb begin
    low_row = 2'd3;
    if (!srow[0])      low_row = 2'd0;
    else if (!srow[1]) low_row = 2'd1;
    else if (!srow[2]) low_row = 2'd2;
  end

  // Decide on this tick whether a press becomes an accepted key and which code it carries.
  always_comb begin
    accept  = 1'b0;
    acc_row = cand_row;
    acc_col = cand_col;
    if (tick) begin
      case (state)
        SCAN: begin
          if (srow != 4'hF && DEBOUNCE_TICKS == 1) begin
            accept  = 1'b1;
            acc_row = low_row;
            acc_col = col;
          end
        end
        DEBOUNCE: begin
          if (cand_pressed && deb_done) accept = 1'b1;
        end
        default: accept = 1'b0;
      endcase
    end
  end

  // Column slot divider; tick marks the last cycle of each slot.
  always_ff @(posedge clk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

  // Two-flop synchronizer for the asynchronous row pads.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'hF;
      srow  <= 4'hF;
    end else begin
      sync1 <= btn_key_row;
      srow  <= sync1;
    end
  end

  // Scan/debounce/held state machine; column only moves on ticks in SCAN or when leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      col      <= 2'd0;
      cand_row <= 2'd0;
      cand_col <= 2'd0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
      key_down <= 1'b0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (srow == 4'hF) begin
            col <= col + 2'd1;
          end else begin
            cand_row <= low_row;
            cand_col <= col;
            if (DEBOUNCE_TICKS == 1) begin
              state    <= HELD;
              rel_cnt  <= '0;
              key_down <= 1'b1;
            end else begin
              deb_cnt <= 8'd1;
              state   <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (cand_pressed) begin
            if (deb_done) begin
              state    <= HELD;
              rel_cnt  <= '0;
              key_down <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + 8'd1;
            end
          end else begin
            state <= SCAN;
            col   <= col + 2'd1;
          end
        end
        HELD: begin
          if (!cand_pressed) begin
            if (rel_done) begin
              state    <= SCAN;
              col      <= col + 2'd1;
              rel_cnt  <= '0;
              key_down <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + 8'd1;
            end
          end else begin
            rel_cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // Single-entry output register with valid/ready handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      overflow  <= 1'b0;
    end else begin
      if (accept && (!key_valid || key_ready)) begin
        key_code  <= {acc_row, acc_col};
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a scoreboard queue of expected key codes.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn_key_col;
  logic [3:0]  btn_key_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_down;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] keys = 16'h0;

  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_key_col(btn_key_col),
    .btn_key_row(btn_key_row),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .key_down   (key_down),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    btn_key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !btn_key_col[c]) btn_key_row[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tickWait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the given column drive pattern has just become active.
  task automatic waitCol(input logic [3:0] target);
    logic [3:0] prev;
    logic       found;
    prev  = btn_key_col;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (btn_key_col == target && prev != target) found = 1'b1;
      prev = btn_key_col;
    end
    checkOutput("wait_col_found", 32'(found), 32'(1));
  endtask

  // Press a key mask at the start of a column slot, hold past acceptance, then release.
  task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] col_drive,
                               input logic [3:0] code, input logic push);
    waitCol(col_drive);
    if (push) exp_q.push_back(code);
    keys = mask;
    tickWait(12);
    checkOutput("press_key_down", 32'(key_down), 32'(1));
    tickWait(4);
    keys = 16'h0;
    tickWait(12);
    checkOutput("release_key_down", 32'(key_down), 32'(0));
  endtask

  // Scoreboard: every completed handshake must match the oldest expected code.
  always @(negedge clk) begin
    #1;
    if (!reset && key_valid && key_ready) begin
      checkOutput("queue_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) checkOutput("delivered_code", 32'(key_code), 32'(exp_q.pop_front()));
    end
  end

  // Directed sequence covering idle scan, clean press, bounce, backpressure, multi-key and reset.
  initial begin
    logic [3:0] seq [4];
    logic [3:0] prev_col;
    logic       found;
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    reset = 1'b1;
    tickWait(3);
    reset = 1'b0;
    checkOutput("reset_col", 32'(btn_key_col), 32'(4'b1110));
    checkOutput("reset_valid", 32'(key_valid), 32'(0));
    checkOutput("reset_code", 32'(key_code), 32'(0));
    checkOutput("reset_down", 32'(key_down), 32'(0));
    checkOutput("reset_ovf", 32'(overflow), 32'(0));

    $display("[TB] idle scan");
    prev_col = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      tickWait(3);
      checkOutput("idle_hold", 32'(btn_key_col), 32'(prev_col));
      tickWait(1);
      checkOutput("idle_step", 32'(btn_key_col), 32'(seq[k]));
      checkOutput("idle_valid", 32'(key_valid), 32'(0));
      prev_col = seq[k];
    end

    $display("[TB] clean press");
    key_ready = 1'b1;
    waitCol(4'b1101);
    exp_q.push_back(4'h9);
    keys = 16'h0200;
    tickWait(11);
    checkOutput("latency_early", 32'(key_valid), 32'(0));
    tickWait(1);
    checkOutput("latency_valid", 32'(key_valid), 32'(1));
    checkOutput("clean_code", 32'(key_code), 32'(4'h9));
    checkOutput("clean_down", 32'(key_down), 32'(1));
    tickWait(1);
    checkOutput("clean_pulse", 32'(key_valid), 32'(0));
    tickWait(67);
    checkOutput("held_col_frozen", 32'(btn_key_col), 32'(4'b1101));
    keys = 16'h0;
    tickWait(11);
    checkOutput("release_down_hold", 32'(key_down), 32'(1));
    tickWait(1);
    checkOutput("release_down_drop", 32'(key_down), 32'(0));
    checkOutput("release_col_next", 32'(btn_key_col), 32'(4'b1011));

    $display("[TB] bounce");
    waitCol(4'b0111);
    keys = 16'h0008;
    tickWait(4);
    checkOutput("bounce_freeze", 32'(btn_key_col), 32'(4'b0111));
    keys = 16'h0;
    tickWait(4);
    checkOutput("bounce_col0", 32'(btn_key_col), 32'(4'b1110));
    checkOutput("bounce_valid", 32'(key_valid), 32'(0));
    checkOutput("bounce_down", 32'(key_down), 32'(0));
    tickWait(4);
    checkOutput("bounce_col1", 32'(btn_key_col), 32'(4'b1101));

    $display("[TB] backpressure");
    key_ready = 1'b0;
    applyStimulus(16'h0020, 4'b1101, 4'h5, 1'b1);
    checkOutput("bp_valid", 32'(key_valid), 32'(1));
    checkOutput("bp_code", 32'(key_code), 32'(4'h5));
    checkOutput("bp_ovf_clear", 32'(overflow), 32'(0));
    applyStimulus(16'h0400, 4'b1011, 4'hA, 1'b0);
    checkOutput("bp_code_kept", 32'(key_code), 32'(4'h5));
    checkOutput("bp_valid_kept", 32'(key_valid), 32'(1));
    checkOutput("bp_ovf_set", 32'(overflow), 32'(1));
    key_ready = 1'b1;
    tickWait(1);
    checkOutput("bp_valid_drop", 32'(key_valid), 32'(0));
    checkOutput("bp_ovf_sticky", 32'(overflow), 32'(1));
    ovf_clr = 1'b1;
    tickWait(1);
    ovf_clr = 1'b0;
    checkOutput("bp_ovf_cleared", 32'(overflow), 32'(0));

    $display("[TB] simultaneous and same-cycle pop");
    key_ready = 1'b0;
    applyStimulus(16'h4040, 4'b1011, 4'h6, 1'b1);
    checkOutput("multi_code", 32'(key_code), 32'(4'h6));
    checkOutput("multi_valid", 32'(key_valid), 32'(1));
    exp_q.push_back(4'hF);
    waitCol(4'b0111);
    keys = 16'h8000;
    tickWait(11);
    key_ready = 1'b1;
    tickWait(1);
    checkOutput("same_cycle_valid", 32'(key_valid), 32'(1));
    checkOutput("same_cycle_code", 32'(key_code), 32'(4'hF));
    checkOutput("same_cycle_ovf", 32'(overflow), 32'(0));
    tickWait(1);
    checkOutput("same_cycle_drop", 32'(key_valid), 32'(0));
    tickWait(3);
    keys = 16'h0;
    tickWait(12);
    checkOutput("same_cycle_release", 32'(key_down), 32'(0));

    $display("[TB] reset while held");
    key_ready = 1'b0;
    waitCol(4'b1101);
    keys = 16'h0002;
    tickWait(12);
    checkOutput("pre_reset_valid", 32'(key_valid), 32'(1));
    checkOutput("pre_reset_down", 32'(key_down), 32'(1));
    reset = 1'b1;
    tickWait(1);
    checkOutput("mid_reset_col", 32'(btn_key_col), 32'(4'b1110));
    checkOutput("mid_reset_valid", 32'(key_valid), 32'(0));
    checkOutput("mid_reset_code", 32'(key_code), 32'(0));
    checkOutput("mid_reset_down", 32'(key_down), 32'(0));
    checkOutput("mid_reset_ovf", 32'(overflow), 32'(0));
    reset = 1'b0;
    exp_q.push_back(4'h1);
    key_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (key_valid) found = 1'b1;
    end
    checkOutput("redetect_found", 32'(found), 32'(1));
    checkOutput("redetect_code", 32'(key_code), 32'(4'h1));
    checkOutput("redetect_down", 32'(key_down), 32'(1));
    tickWait(4);
    keys = 16'h0;
    tickWait(20);
    checkOutput("redetect_release", 32'(key_down), 32'(0));

    checkOutput("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
